rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_pkg.sv | 14 +
 rtl/rr_arb2.sv | 47 ++++
 rtl/rf_wb_arbiter.sv | 67 ++++++
 tb/tb_rf_wb_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared widths, priority-state type and register-zero constant for the
// register-file writeback arbiter and its round-robin grant core.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int REG_ZERO  = 0;

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_MEM = 1'b1
    } pri_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant logic. The priority flop names the requester
// that wins a tie and flips to the loser after every grant.
module rr_arb2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    pri_e state;
    pri_e state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PRI_ALU;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are combinational so a requester is accepted in the cycle it asks.
    always_comb begin
        gnt_alu   = 1'b0;
        gnt_mem   = 1'b0;
        state_nxt = state;
        if (!rst && !hold) begin
            if (req_alu && req_mem) begin
                gnt_alu = (state == PRI_ALU);
                gnt_mem = (state == PRI_MEM);
            end else begin
                gnt_alu = req_alu;
                gnt_mem = req_mem;
            end
        end
        if (gnt_alu) begin
            state_nxt = PRI_MEM;
        end else if (gnt_mem) begin
            state_nxt = PRI_ALU;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register-file write port,
// registering the winning write and dropping writes aimed at register zero.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              alu_vld,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_rdy,
    input  logic              mem_vld,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_rdy,
    output logic              we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst,
    output logic              x0_drop
);

    logic              gnt_alu;
    logic              gnt_mem;
    logic              xfer;
    logic              to_zero;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .req_alu (alu_vld),
        .req_mem (mem_vld),
        .gnt_alu (gnt_alu),
        .gnt_mem (gnt_mem)
    );

    assign alu_rdy  = gnt_alu;
    assign mem_rdy  = gnt_mem;
    assign xfer     = gnt_alu | gnt_mem;
    assign sel_addr = gnt_mem ? mem_addr : alu_addr;
    assign sel_data = gnt_mem ? mem_data : alu_data;
    assign to_zero  = (sel_addr == ADDR_W'(REG_ZERO));

    // Register-zero writes never reach the port; dst_addr/dst keep the last real write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we       <= 1'b0;
            x0_drop  <= 1'b0;
            dst_addr <= '0;
            dst      <= '0;
        end else begin
            we      <= xfer && !to_zero;
            x0_drop <= xfer && to_zero;
            if (xfer && !to_zero) begin
                dst_addr <= sel_addr;
                dst      <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        alu_vld;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_rdy;
    logic        mem_vld;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_rdy;
    logic        we;
    logic [4:0]  dst_addr;
    logic [31:0] dst;
    logic        x0_drop;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model of the register-file port as seen by the next cycle.
    logic        m_we;
    logic        m_x0;
    logic [4:0]  m_addr;
    logic [31:0] m_dst;
    logic        m_alu_turn;

    logic        s_alu_rdy;
    logic        s_mem_rdy;

    rf_wb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .alu_vld  (alu_vld),
        .alu_addr (alu_addr),
        .alu_data (alu_data),
        .alu_rdy  (alu_rdy),
        .mem_vld  (mem_vld),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_rdy  (mem_rdy),
        .we       (we),
        .dst_addr (dst_addr),
        .dst      (dst),
        .x0_drop  (x0_drop)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input logic e_alu, input logic e_mem);
        compare("we", 32'(we), 32'(m_we));
        compare("x0_drop", 32'(x0_drop), 32'(m_x0));
        compare("dst_addr", 32'(dst_addr), 32'(m_addr));
        compare("dst", dst, m_dst);
        compare("alu_rdy", 32'(alu_rdy), 32'(e_alu));
        compare("mem_rdy", 32'(mem_rdy), 32'(e_mem));
    endtask

    // Called at a falling edge: drives one cycle of inputs, checks, advances the model.
    task automatic applyStimulus(input logic r, input logic h,
                                 input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] ma, input logic [31:0] md);
        logic        e_alu;
        logic        e_mem;
        logic [4:0]  t_addr;
        logic [31:0] t_data;
        rst = r; hold = h;
        alu_vld = av; alu_addr = aa; alu_data = ad;
        mem_vld = mv; mem_addr = ma; mem_data = md;
        if (r) begin
            m_we = 1'b0; m_x0 = 1'b0; m_addr = '0; m_dst = '0; m_alu_turn = 1'b1;
        end
        #1;
        e_alu = 1'b0;
        e_mem = 1'b0;
        if (!r && !h) begin
            if (av && mv) begin
                e_alu = m_alu_turn;
                e_mem = !m_alu_turn;
            end else begin
                e_alu = av;
                e_mem = mv;
            end
        end
        checkOutput(e_alu, e_mem);
        s_alu_rdy = alu_rdy;
        s_mem_rdy = mem_rdy;
        m_we = 1'b0;
        m_x0 = 1'b0;
        if (e_alu || e_mem) begin
            t_addr = e_alu ? aa : ma;
            t_data = e_alu ? ad : md;
            if (t_addr == 5'd0) begin
                m_x0 = 1'b1;
            end else begin
                m_we = 1'b1; m_addr = t_addr; m_dst = t_data;
            end
            m_alu_turn = e_mem;
        end
        @(negedge clk);
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        logic        av, mv;
        logic [4:0]  aa, ma;
        logic [31:0] ad, md;
        logic        r, h;

        @(negedge clk);
        resetDut();
        compare("reset_we", 32'(we), 32'd0);
        compare("reset_dst", dst, 32'd0);

        // Single ALU write.
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        compare("lit_alu_rdy", 32'(s_alu_rdy), 32'd1);
        compare("lit_we", 32'(we), 32'd1);
        compare("lit_dst_addr", 32'(dst_addr), 32'd5);
        compare("lit_dst", dst, 32'hDEADBEEF);

        // Both valid for four cycles: ALU, MEM, ALU, MEM.
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
            compare("lit_alt_alu", 32'(s_alu_rdy), (i % 2 == 0) ? 32'd1 : 32'd0);
            compare("lit_alt_dst", dst, (i % 2 == 0) ? 32'h11 : 32'h22);
        end

        // Same address from both sides: serialized in grant order.
        resetDut();
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd9, 32'hBBBB);
        compare("lit_same1", dst, 32'hAAAA);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hBBBB);
        compare("lit_same2", dst, 32'hBBBB);
        compare("lit_same2_we", 32'(we), 32'd1);

        // Load aimed at register zero is dropped.
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        compare("lit_x0_rdy", 32'(s_mem_rdy), 32'd1);
        compare("lit_x0_we", 32'(we), 32'd0);
        compare("lit_x0_drop", 32'(x0_drop), 32'd1);

        // ALU stream with hold in cycles 3-4.
        resetDut();
        for (int c = 1; c <= 7; c++) begin
            applyStimulus(1'b0, (c == 3 || c == 4), 1'b1, 5'(c + 10), 32'(c), 1'b0, 5'd0, 32'd0);
            compare("lit_hold_rdy", 32'(s_alu_rdy), (c == 3 || c == 4) ? 32'd0 : 32'd1);
        end

        // Reset one cycle after an accepted write.
        resetDut();
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        compare("lit_rst_we", 32'(we), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88);
        compare("lit_rst_alu_first", 32'(s_alu_rdy), 32'd1);

        // Randomized traffic; an ungranted requester keeps its request stable.
        resetDut();
        av = 1'b0; mv = 1'b0; aa = '0; ma = '0; ad = '0; md = '0;
        for (int n = 0; n < 600; n++) begin
            if (!(av && !s_alu_rdy)) begin
                av = ($urandom_range(0, 3) != 0);
                aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                ad = $urandom;
            end
            if (!(mv && !s_mem_rdy)) begin
                mv = ($urandom_range(0, 2) != 0);
                ma = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                md = $urandom;
            end
            r = ($urandom_range(0, 49) == 0);
            h = ($urandom_range(0, 7) == 0);
            applyStimulus(r, h, av, aa, ad, mv, ma, md);
            if (r) begin
                s_alu_rdy = 1'b1;
                s_mem_rdy = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
